// File: rtl/filter_result_checker.sv
// Purpose : framed capture and self-check of filter output samples against a golden ROM.
// Latency : capture write appears 1 cycle after accept; stats update 1 cycle after that; done 2 cycles after the last accept.
// Backpressure: none; sample_valid gaps stall the index, samples outside SKIP/RUN are dropped.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               frame start pulse (honoured in IDLE and DONE only)
//   sample_valid/in     filter output sample stream (two's complement)
//   exp_addr / exp_q    golden ROM address (comb copy of index) / registered ROM data
//   wr_en/addr/data     capture RAM write port (registered)
//   busy, done, pass    frame status
//   err_count, first_err_addr, max_abs_err   error statistics, held in DONE
module filter_result_checker #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int NUM_SAMPLES = 256,
    parameter int SKIP        = 0,
    parameter int TOL         = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    output logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_q,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] max_abs_err
);

    localparam int                SKIP_W    = 8;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_SAMPLES - 1);
    localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(SKIP);
    localparam logic [DATA_W:0]   TOL_EXT   = (DATA_W+1)'(TOL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;

    // Stage 1: accepted sample waiting for its golden word from the ROM.
    logic                s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0]   s1_dat_q, s1_dat_d;
    logic [ADDR_W-1:0]   s1_idx_q, s1_idx_d;

    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic [15:0]         err_q, err_d;
    logic [ADDR_W-1:0]   first_q, first_d;
    logic [DATA_W-1:0]   max_q, max_d;

    // Difference is formed one bit wider so that extreme operands cannot overflow.
    logic [DATA_W:0]     diff;
    logic [DATA_W:0]     abs_ext;
    logic [DATA_W-1:0]   abs_sat;
    logic                mismatch;

    always_comb begin
        diff     = {s1_dat_q[DATA_W-1], s1_dat_q} - {exp_q[DATA_W-1], exp_q};
        abs_ext  = diff[DATA_W] ? (~diff + (DATA_W+1)'(1)) : diff;
        abs_sat  = abs_ext[DATA_W] ? {DATA_W{1'b1}} : abs_ext[DATA_W-1:0];
        mismatch = s1_vld_q && (abs_ext > TOL_EXT);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        skip_d    = skip_q;
        s1_vld_d  = 1'b0;
        s1_dat_d  = s1_dat_q;
        s1_idx_d  = s1_idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
        first_d   = first_q;
        max_d     = max_q;

        // Compare stage: runs whenever stage 1 holds an accepted sample.
        if (s1_vld_q) begin
            if (mismatch) begin
                if (err_q != 16'hFFFF) begin
                    err_d = err_q + 16'd1;
                end
                // err_count never returns to zero within a frame, so zero marks "no mismatch yet".
                if (err_q == 16'd0) begin
                    first_d = s1_idx_q;
                end
            end
            if (abs_sat > max_q) begin
                max_d = abs_sat;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    err_d   = '0;
                    first_d = '0;
                    max_d   = '0;
                    idx_d   = '0;
                    skip_d  = SKIP_INIT;
                    state_d = (SKIP == 0) ? S_RUN : S_SKIP;
                end
            end
            S_SKIP: begin
                if (sample_valid) begin
                    skip_d = skip_q - SKIP_W'(1);
                    if (skip_q == SKIP_W'(1)) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (sample_valid) begin
                    s1_vld_d  = 1'b1;
                    s1_dat_d  = sample_in;
                    s1_idx_d  = idx_q;
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = sample_in;
                    // Index holds on the last sample so it never wraps inside a frame.
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            skip_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_dat_q  <= '0;
            s1_idx_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= '0;
            first_q   <= '0;
            max_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            skip_q    <= skip_d;
            s1_vld_q  <= s1_vld_d;
            s1_dat_q  <= s1_dat_d;
            s1_idx_q  <= s1_idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
            first_q   <= first_d;
            max_q     <= max_d;
        end
    end

    assign exp_addr       = idx_q;
    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign busy           = (state_q == S_SKIP) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign pass           = (state_q == S_DONE) && (err_q == 16'd0);
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign max_abs_err    = max_q;

endmodule

// File: tb/tb_filter_result_checker.sv
// Purpose : scoreboard bench for filter_result_checker; three instances cover TOL=0, TOL=5 and SKIP=4.
// Latency : capture writes are matched in order against queued expectations at the falling edge.
// Backpressure: none; stimulus drives sample_valid directly, with optional one-cycle gaps.
module tb_filter_result_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [31:0] sample_in;
    logic [2:0]  start_v;

    logic [7:0]  exp_addr_w [3];
    logic [31:0] exp_q_w    [3];
    logic        wr_en_w    [3];
    logic [7:0]  wr_addr_w  [3];
    logic [31:0] wr_data_w  [3];
    logic        busy_w     [3];
    logic        done_w     [3];
    logic        pass_w     [3];
    logic [15:0] err_w      [3];
    logic [7:0]  first_w    [3];
    logic [31:0] max_w      [3];

    logic [31:0] golden [256];
    logic [31:0] samp   [256];
    logic [39:0] sb_q [$];
    logic [7:0]  exp_idx;
    int          sel;
    int          n_checks;
    int          n_fails;

    always #5 clk = ~clk;

    filter_result_checker #(.DATA_W(32), .ADDR_W(8), .NUM_SAMPLES(256), .SKIP(0), .TOL(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .sample_valid(sample_valid), .sample_in(sample_in),
        .exp_addr(exp_addr_w[0]), .exp_q(exp_q_w[0]), .wr_en(wr_en_w[0]), .wr_addr(wr_addr_w[0]),
        .wr_data(wr_data_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .first_err_addr(first_w[0]), .max_abs_err(max_w[0]));

    filter_result_checker #(.DATA_W(32), .ADDR_W(8), .NUM_SAMPLES(256), .SKIP(0), .TOL(5)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .sample_valid(sample_valid), .sample_in(sample_in),
        .exp_addr(exp_addr_w[1]), .exp_q(exp_q_w[1]), .wr_en(wr_en_w[1]), .wr_addr(wr_addr_w[1]),
        .wr_data(wr_data_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .first_err_addr(first_w[1]), .max_abs_err(max_w[1]));

    filter_result_checker #(.DATA_W(32), .ADDR_W(8), .NUM_SAMPLES(256), .SKIP(4), .TOL(0)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .sample_valid(sample_valid), .sample_in(sample_in),
        .exp_addr(exp_addr_w[2]), .exp_q(exp_q_w[2]), .wr_en(wr_en_w[2]), .wr_addr(wr_addr_w[2]),
        .wr_data(wr_data_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(err_w[2]), .first_err_addr(first_w[2]), .max_abs_err(max_w[2]));

    // Golden ROMs with one-cycle registered read.
    always @(posedge clk) begin
        for (int j = 0; j < 3; j++) begin
            exp_q_w[j] <= golden[exp_addr_w[j]];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Write monitor: every capture write of the observed instance must match the scoreboard head.
    always @(negedge clk) begin
        if (wr_en_w[sel] === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                logic [39:0] e;
                e = sb_q.pop_front();
                check("wr_addr", wr_addr_w[sel], e[39:32]);
                check("wr_data", wr_data_w[sel], e[31:0]);
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit push);
        sample_valid = 1'b1;
        sample_in    = d;
        if (push) begin
            sb_q.push_back({exp_idx, d});
            exp_idx++;
        end
        @(posedge clk) #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        sample_valid = 1'b0;
        sample_in    = $urandom;
        @(posedge clk) #1;
    endtask

    task automatic run_frame(input logic [2:0] m, input int nskip, input bit gaps,
                             input bit poke, input int n_acc);
        @(posedge clk) #1;
        start_v = m;
        @(posedge clk) #1;
        start_v = '0;
        @(negedge clk);
        check("start_busy", busy_w[sel], 1);
        check("start_done", done_w[sel], 0);
        check("start_err", err_w[sel], 0);
        check("start_max", max_w[sel], 0);
        exp_idx = '0;
        for (int k = 0; k < nskip; k++) begin
            send($urandom, 1'b0);
            if (gaps) idle_cycle();
        end
        for (int i = 0; i < n_acc; i++) begin
            if (poke && i == 50) start_v = m;
            send(samp[i], 1'b1);
            start_v = '0;
            if (gaps && i < n_acc - 1) idle_cycle();
        end
        if (n_acc == 256) begin
            @(negedge clk);
            check("drain_busy", busy_w[sel], 1);
            check("drain_done", done_w[sel], 0);
            @(negedge clk);
            check("end_busy", busy_w[sel], 0);
            check("end_done", done_w[sel], 1);
            #1;
            check("sb_empty", sb_q.size(), 0);
        end
    endtask

    task automatic check_stats(input int j, input logic [15:0] e_err, input logic [7:0] e_first,
                               input logic [31:0] e_max, input logic e_pass);
        check("done", done_w[j], 1);
        check("err_count", err_w[j], e_err);
        check("first_err_addr", first_w[j], e_first);
        check("max_abs_err", max_w[j], e_max);
        check("pass", pass_w[j], e_pass);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        sel          = 0;
        rst          = 1'b0;
        start_v      = '0;
        sample_valid = 1'b0;
        sample_in    = '0;
        exp_idx      = '0;
        for (int i = 0; i < 256; i++) begin
            golden[i] = ($urandom & 32'h0FFF_FFFF) - 32'h0800_0000;
            samp[i]   = golden[i];
        end

        // Reset state
        @(negedge clk);
        check("rst_wr_en", wr_en_w[0], 0);
        check("rst_busy", busy_w[0], 0);
        check("rst_done", done_w[0], 0);
        check("rst_pass", pass_w[0], 0);
        check("rst_err", err_w[0], 0);
        check("rst_first", first_w[0], 0);
        check("rst_max", max_w[0], 0);
        check("rst_exp_addr", exp_addr_w[0], 0);
        rst = 1'b1;

        // Reset in the middle of RUN after 10 accepts, one of them mismatching
        samp[3] = golden[3] ^ 32'h1;
        run_frame(3'b001, 0, 1'b0, 1'b0, 10);
        @(negedge clk);
        #1;
        check("pre_rst_err", err_w[0], 1);
        rst = 1'b0;
        #1;
        check("mid_rst_wr_en", wr_en_w[0], 0);
        check("mid_rst_busy", busy_w[0], 0);
        check("mid_rst_done", done_w[0], 0);
        check("mid_rst_err", err_w[0], 0);
        check("mid_rst_idx", exp_addr_w[0], 0);
        repeat (3) begin
            sample_valid = 1'b1;
            sample_in    = $urandom;
            @(posedge clk) #1;
        end
        sample_valid = 1'b0;
        @(negedge clk) #2;
        rst     = 1'b1;
        samp[3] = golden[3];

        // Clean frame with a start pulse ignored mid-RUN
        run_frame(3'b001, 0, 1'b0, 1'b1, 256);
        check_stats(0, 16'd0, 8'd0, 32'd0, 1'b1);

        // +3 at 17, -5 at 200 on TOL=0 and TOL=5 instances together
        samp[17]  = golden[17] + 32'd3;
        samp[200] = golden[200] - 32'd5;
        run_frame(3'b011, 0, 1'b0, 1'b0, 256);
        check_stats(0, 16'd2, 8'd17, 32'd5, 1'b0);
        check_stats(1, 16'd0, 8'd0, 32'd5, 1'b1);
        samp[17]  = golden[17];
        samp[200] = golden[200];

        // Extreme operands; start from DONE clears the previous errors
        golden[9] = 32'h8000_0000;
        samp[9]   = 32'h7FFF_FFFF;
        run_frame(3'b001, 0, 1'b0, 1'b0, 256);
        check_stats(0, 16'd1, 8'd9, 32'hFFFF_FFFF, 1'b0);
        golden[9] = ($urandom & 32'h0FFF_FFFF) - 32'h0800_0000;
        samp[9]   = golden[9];

        // SKIP=4 with valid toggling every other cycle
        @(negedge clk);
        sel = 2;
        run_frame(3'b100, 4, 1'b1, 1'b0, 256);
        check_stats(2, 16'd0, 8'd0, 32'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
